// File: rtl/rx_comma_align_pkg.sv
// Shared constants and types for the 8b10b receive aligner and its comma detector.
package rx_comma_align_pkg;

    localparam int unsigned SYM_W = 10;

    localparam logic [SYM_W-1:0] K28P5_NEG = 10'h0FA;
    localparam logic [SYM_W-1:0] K28P5_POS = 10'h305;

    typedef enum logic [1:0] {
        HUNT,
        CHECK,
        LOCKED
    } state_e;

endpackage

// File: rtl/rx_comma_align_comma_det.sv
// Combinational K28.5 matcher: flags either running-disparity form of the comma.
module rx_comma_align_comma_det
    import rx_comma_align_pkg::*;
(
    input  logic [SYM_W-1:0] word,
    output logic             match
);

    assign match = (word == K28P5_NEG) || (word == K28P5_POS);

endmodule

// File: rtl/rx_comma_align.sv
// Serial-to-10b deserializer with K28.5 comma alignment and a HUNT/CHECK/LOCKED lock FSM.
module rx_comma_align
    import rx_comma_align_pkg::*;
#(
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned ERR_LIM  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    input  logic             err_in,
    output logic [SYM_W-1:0] dout,
    output logic             dout_vld,
    output logic             comma,
    output logic             locked
);

    localparam int unsigned CC_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned EC_W = $clog2(ERR_LIM + 1);
    localparam logic [CC_W:0] LOCK_TOP = (CC_W + 1)'(LOCK_CNT);
    localparam logic [EC_W:0] ERR_TOP  = (EC_W + 1)'(ERR_LIM);

    // Only the low 9 bits of the shift register ever reach the window.
    logic [SYM_W-2:0] sr_q, sr_d;
    logic [3:0]       bcnt_q, bcnt_d;
    logic [CC_W-1:0]  cc_q, cc_d;
    logic [EC_W-1:0]  ec_q, ec_d;
    state_e           state_q, state_d;
    logic [SYM_W-1:0] dout_q, dout_d;
    logic             vld_q, vld_d;
    logic             comma_q, comma_d;

    logic [SYM_W-1:0] w;
    logic             match;
    logic             at_nine;
    logic             boundary;
    logic             emit;
    logic [CC_W:0]    cc_inc;
    logic [EC_W:0]    ec_inc;

    assign w       = {sr_q, sin};
    assign at_nine = (bcnt_q == 4'd9);
    assign cc_inc  = {1'b0, cc_q} + 1'b1;
    assign ec_inc  = {1'b0, ec_q} + 1'b1;

    rx_comma_align_comma_det u_comma_det (
        .word  (w),
        .match (match)
    );

    always_comb begin
        state_d  = state_q;
        cc_d     = cc_q;
        ec_d     = ec_q;
        sr_d     = sr_q;
        dout_d   = dout_q;
        vld_d    = 1'b0;
        comma_d  = 1'b0;
        boundary = en && at_nine;
        emit     = 1'b0;

        if (en) begin
            sr_d = w[SYM_W-2:0];
        end

        unique case (state_q)
            HUNT: begin
                if (en && match) begin
                    boundary = 1'b1;
                    emit     = 1'b1;
                    cc_d     = CC_W'(1);
                    if (LOCK_CNT == 1) begin
                        state_d = LOCKED;
                        ec_d    = '0;
                    end else begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                // A decoder error abandons acquisition even if a comma lands now.
                if (err_in) begin
                    state_d = HUNT;
                    cc_d    = '0;
                end else if (en) begin
                    if (match && !at_nine) begin
                        boundary = 1'b1;
                        cc_d     = CC_W'(1);
                    end else if (match) begin
                        cc_d = cc_inc[CC_W-1:0];
                        if (cc_inc >= LOCK_TOP) begin
                            state_d = LOCKED;
                            ec_d    = '0;
                        end
                    end
                    emit = boundary;
                end
            end
            LOCKED: begin
                emit = boundary;
                // err_in and a misaligned comma together are a single event.
                if (err_in || (en && match && !at_nine)) begin
                    if (ec_inc >= ERR_TOP) begin
                        state_d = HUNT;
                        ec_d    = '0;
                        cc_d    = '0;
                    end else begin
                        ec_d = ec_inc[EC_W-1:0];
                    end
                end else if (en && match && at_nine) begin
                    ec_d = '0;
                end
            end
            default: state_d = HUNT;
        endcase

        if (emit) begin
            dout_d  = w;
            vld_d   = 1'b1;
            comma_d = match;
        end

        if (boundary) begin
            bcnt_d = 4'd0;
        end else if (en) begin
            bcnt_d = bcnt_q + 4'd1;
        end else begin
            bcnt_d = bcnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q    <= '0;
            bcnt_q  <= 4'd0;
            cc_q    <= '0;
            ec_q    <= '0;
            state_q <= HUNT;
            dout_q  <= '0;
            vld_q   <= 1'b0;
            comma_q <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            bcnt_q  <= bcnt_d;
            cc_q    <= cc_d;
            ec_q    <= ec_d;
            state_q <= state_d;
            dout_q  <= dout_d;
            vld_q   <= vld_d;
            comma_q <= comma_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign comma    = comma_q;
    assign locked   = (state_q == LOCKED);

endmodule
